sqrt_iter_engine: RTL and testbench
===================================

Name: sqrt_iter_engine

Overview:
Sequential digit-by-digit integer square-root engine for the square-root-finder datapath.
- Sits directly upstream of the switch/LED/7-segment display stage.
- Accepts an unsigned radicand (switch value, zero-extended) on a start pulse.
- Iterates one result bit per clock and presents root and remainder with a done/valid handshake for the display stage to consume.

Parameters:
WIDTH, 8, radicand width in bits; must be even and >= 4
ROOT_W, WIDTH/2+1, root output width; the extra MSB carries the rounding carry

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
radicand  input  WIDTH  unsigned operand; sampled on the accepting edge
busy  output  1  high while computing
done  output  1  one-cycle pulse when the result becomes valid
valid  output  1  high from done until the next accepted start
root  output  ROOT_W  integer square root
remainder  output  WIDTH/2+1  radicand minus truncated root squared

Behaviour:
- Reset: one clock `clk`; asynchronous active-low reset `rst_n`.
  - Assertion forces state IDLE immediately.
  - busy=0, done=0, valid=0, root=0, remainder=0.
  - Internal registers are cleared.
- States and transitions:
  - IDLE: start=1 latches radicand into num, clears res, loads bit=1<<(WIDTH-2), clears valid -> CALC.
  - CALC: busy=1. Each cycle:
    - if num >= res+bit: num -= res+bit; res = (res>>1)+bit
    - else: res = res>>1
    - then bit >>= 2
    - After exactly WIDTH/2 CALC cycles -> DONE.
  - DONE: lasts one cycle. done=1, busy=0, root/remainder registered, valid=1 -> IDLE.
- Latency:
  - start accepted at edge N: busy visible after edge N.
  - done high after edge N+WIDTH/2+1 for exactly one cycle.
  - For WIDTH=8: 5 cycles start-to-done.
- start while busy (CALC or DONE) is ignored; it is neither queued nor able to corrupt the operation.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE, giving back-to-back results every WIDTH/2+2 cycles.
- Result holding:
  - root/remainder hold their last values through IDLE until the next DONE.
  - valid drops on the accepting start edge; root/remainder keep their old values until the new DONE.
- Arithmetic width rules:
  - Compare/subtract path is WIDTH+1 bits so res+bit cannot overflow.
  - remainder <= 2*root always fits WIDTH/2+1 bits.
- Boundary values:
  - radicand=0 gives root 0, rem 0.
  - All-ones radicand gives root 2^(WIDTH/2)-1, rem 2*root.
- Reset asserted mid-CALC: operation aborts; all outputs return to reset values; no done pulse.

Optional Feature:
SQRT_ROUND_EN
- Defined: in the DONE state, if remainder > truncated root, root = truncated root + 1 (round to nearest); otherwise root = truncated root. Latency is unchanged.
- Undefined: root is the truncated root, and root[ROOT_W-1] is always 0.
- In both cases remainder is relative to the truncated root.

Decomposition:
- Package sqrt_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - default WIDTH constant
  - localparam function for the iteration count (WIDTH/2)
- One natural sub-module: sqrt_step. It is purely combinational: given num, res, bit, it returns next num/res. This keeps the compare/subtract path separately testable.
- The FSM, counters and result registers stay in sqrt_iter_engine.

Test Plan:
- radicand=127, start pulse -> done 5 cycles later; root=11, remainder=6; with SQRT_ROUND_EN root=11.
- radicand=46 -> root=6, remainder=10; with SQRT_ROUND_EN root=7; valid stays high until the next start.
- radicand=0, then 255, then 64, back-to-back with start held high -> (0,0), (15,30), (8,0), done pulses spaced 6 cycles apart.
- start re-pulsed with radicand=9 two cycles into computing 127 -> ignored; single done with root=11, rem=6; no second done.
- rst_n asserted low on the 2nd CALC cycle of radicand=200 -> busy/valid/root/remainder drop to 0 immediately; no done; next start with 200 gives root=14, rem=4.
- Exhaustive sweep of radicand 0..255 -> root*root + remainder == radicand and remainder <= 2*root for every value.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the digit-by-digit square-root engine.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int iter_count(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: conditional subtract of res+bit from num.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0] num_i,
  input  logic [WIDTH:0] res_i,
  input  logic [WIDTH:0] bit_i,
  output logic [WIDTH:0] num_o,
  output logic [WIDTH:0] res_o
);

  logic [WIDTH:0] trial_s;

  // Compare/subtract on a WIDTH+1 bit path so res+bit never wraps
  always_comb begin
    trial_s = res_i + bit_i;
    num_o   = num_i;
    res_o   = res_i >> 1;
    if (num_i >= trial_s) begin
      num_o = num_i - trial_s;
      res_o = (res_i >> 1) + bit_i;
    end else begin
      num_o = num_i;
      res_o = res_i >> 1;
    end
  end

endmodule

// File: rtl/sqrt_iter_engine.sv
// Sequential integer square root, one root bit per clock with done/valid handshake.
// Optional round-to-nearest root when SQRT_ROUND_EN is defined.
module sqrt_iter_engine
  import sqrt_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ROOT_W = WIDTH / 2 + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [ROOT_W-1:0]    root,
  output logic [WIDTH/2:0]     remainder
);

  localparam int ITER  = iter_count(WIDTH);
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [WIDTH:0] BIT_INIT = {3'b001, {(WIDTH-2){1'b0}}};

  sqrt_state_e        state_q;
  logic [WIDTH:0]     num_q, res_q, bit_q;
  logic [WIDTH:0]     num_d, res_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, valid_q;
  logic [ROOT_W-1:0]  root_q, root_d, root_trunc_s;
  logic [WIDTH/2:0]   rem_q, rem_s;

  sqrt_step #(.WIDTH(WIDTH)) u_step (
    .num_i (num_q),
    .res_i (res_q),
    .bit_i (bit_q),
    .num_o (num_d),
    .res_o (res_d)
  );

  // Final root selection; remainder always refers to the truncated root
  always_comb begin
    root_trunc_s = ROOT_W'(res_q[WIDTH/2-1:0]);
    rem_s        = num_q[WIDTH/2:0];
    root_d       = root_trunc_s;
`ifdef SQRT_ROUND_EN
    if (ROOT_W'(rem_s) > root_trunc_s) begin
      root_d = root_trunc_s + ROOT_W'(1);
    end else begin
      root_d = root_trunc_s;
    end
`endif
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      res_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            num_q   <= {1'b0, radicand};
            res_q   <= '0;
            bit_q   <= BIT_INIT;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          num_q <= num_d;
          res_q <= res_d;
          bit_q <= bit_q >> 2;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= CALC;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          root_q  <= root_d;
          rem_q   <= rem_s;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign root      = root_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_sqrt_iter_engine.sv
// Directed self-checking bench for sqrt_iter_engine (WIDTH=8); honours SQRT_ROUND_EN.
module tb_sqrt_iter_engine;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] radicand;
  logic       busy, done, valid;
  logic [4:0] root, remainder;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  sqrt_iter_engine #(.WIDTH(8), .ROOT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .radicand  (radicand),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .root      (root),
    .remainder (remainder)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int isqrt(input int r);
    int q = 0;
    while ((q + 1) * (q + 1) <= r) q++;
    return q;
  endfunction

  function automatic int exp_root(input int r);
    int t;
    t = isqrt(r);
`ifdef SQRT_ROUND_EN
    if (r - t * t > t) return t + 1;
`endif
    return t;
  endfunction

  // Pulse start with r, wait (bounded) for done; lat counts edges after the accepting edge
  task automatic run_op(input logic [7:0] r, output logic [4:0] ro, output logic [4:0] rm,
                        output int lat);
    radicand = r;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    do begin
      tick();
      lat++;
    end while (!done && lat < 20);
    ro = root;
    rm = remainder;
  endtask

  initial begin
    logic [4:0] ro, rm;
    int lat, n, last_cyc, ndone, t;
    logic [7:0] b2b [3];
    b2b[0] = 8'd0;
    b2b[1] = 8'd255;
    b2b[2] = 8'd64;

    // Reset state
    rst_n = 1'b0; start = 1'b0; radicand = 8'd0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_root", root, 0);
    check("rst_rem", remainder, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // radicand 127 with explicit cycle-by-cycle latency
    radicand = 8'd127; start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_after_accept", busy, 1);
    check("t1_valid_low", valid, 0);
    for (int i = 0; i < 4; i++) tick();
    check("t1_no_early_done", done, 0);
    check("t1_busy_done_state", busy, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_root", root, exp_root(127));
    check("t1_rem", remainder, 6);
    check("t1_valid", valid, 1);
    check("t1_busy_low", busy, 0);
    tick();
    check("t1_done_one_cycle", done, 0);
    check("t1_root_hold", root, exp_root(127));

    // radicand 46; result and valid persist through idle
    run_op(8'd46, ro, rm, lat);
    check("t2_latency", lat, 5);
    check("t2_root", ro, exp_root(46));
    check("t2_rem", rm, 10);
    for (int i = 0; i < 4; i++) tick();
    check("t2_valid_hold", valid, 1);
    check("t2_root_hold", root, exp_root(46));
    check("t2_rem_hold", remainder, 10);

    // Back-to-back with start held: 0, 255, 64
    radicand = b2b[0]; start = 1'b1;
    tick();
    check("t3_valid_drop", valid, 0);
    check("t3_root_keep", root, exp_root(46));
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 20);
      check("t3_done_seen", done, 1);
      check("t3_root", root, exp_root(b2b[k]));
      check("t3_rem", remainder, b2b[k] - isqrt(b2b[k]) * isqrt(b2b[k]));
      if (k > 0) check("t3_spacing", cyc - last_cyc, 6);
      last_cyc = cyc;
      if (k < 2) radicand = b2b[k + 1];
      else start = 1'b0;
    end

    // start re-pulsed mid-computation is ignored
    radicand = 8'd127; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    radicand = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) begin
        ndone++;
        check("t4_root", root, exp_root(127));
        check("t4_rem", remainder, 6);
      end
    end
    check("t4_single_done", ndone, 1);

    // Reset in the 2nd CALC cycle aborts the operation
    radicand = 8'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valid", valid, 0);
    check("t5_root", root, 0);
    check("t5_rem", remainder, 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) ndone++;
    end
    check("t5_no_done", ndone, 0);
    rst_n = 1'b1;
    tick();
    run_op(8'd200, ro, rm, lat);
    check("t5_latency", lat, 5);
    check("t5_root_after", ro, exp_root(200));
    check("t5_rem_after", rm, 4);

    // Exhaustive sweep
    for (int r = 0; r < 256; r++) begin
      run_op(8'(r), ro, rm, lat);
      t = isqrt(r);
      check("sweep_latency", lat, 5);
      check("sweep_root", ro, exp_root(r));
      check("sweep_rem", rm, r - t * t);
      check("sweep_identity", t * t + int'(rm), r);
      check("sweep_rem_bound", (int'(rm) <= 2 * t), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
